// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   - Buffer geometry (8-bit entries, 32 deep, 5-bit address).
//   - Default bit period for 115200 baud from a 100 MHz clock.
//   - Controller state encoding and the start-length clamp helper.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int BUF_DEPTH            = 32;
    localparam int BUF_AW               = 5;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        DONE
    } tx_state_e;

    // Requests longer than the buffer are trimmed to a full buffer.
    function automatic logic [5:0] clamp_len(input logic [5:0] l);
        return (l > 6'd32) ? 6'd32 : l;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART frame serializer.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   tx_start          one-cycle request to send tx_data (taken only when idle)
//   tx_data[7:0]      byte to send, latched with tx_start
//   tx                serial line, idles high
//   frame_done        pulses on the last cycle of the stop bit
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_start,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx,
    output logic                   frame_done
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    logic                   active_q, active_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;   // 0 = start, 1..8 = data, 9 = stop
    logic [BW-1:0]          baud_q, baud_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   bit_end;

    assign bit_end    = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign frame_done = active_q && (bit_cnt_q == 4'd9) && bit_end;
    assign tx         = tx_q;

    always_comb begin
        active_d  = active_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        if (!active_q) begin
            if (tx_start) begin
                active_d  = 1'b1;
                bit_cnt_d = 4'd0;
                baud_d    = '0;
                shift_d   = tx_data;
                tx_d      = 1'b0;
            end
        end else if (bit_end) begin
            baud_d = '0;
            if (bit_cnt_q == 4'd9) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd8) begin
                    tx_d = 1'b1;
                end else begin
                    // tx is registered, so the next bit is taken from the
                    // shifter one cycle ahead of the bit boundary.
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
        end else begin
            baud_d = baud_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= 1'b0;
            bit_cnt_q <= 4'd0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
        end else begin
            active_q  <= active_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/uart_tx_streamer.sv
// Buffered UART transmit streamer.
// A host fills a 32 x 8 buffer by address; a start command sends the first
// len bytes (clamped to 32) as back-to-back 8N1 frames.
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   wr_en, wr_addr, wr_data      buffer write port, usable in any state
//   start, len                   stream request, sampled only in IDLE
//   tx                           UART serial line
//   busy                         stream in progress
//   done                         one-cycle pulse when the stream completes
//   rd_addr                      address of the byte being fetched/sent
module uart_tx_streamer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [BUF_AW-1:0]      wr_addr,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   start,
    input  logic [5:0]             len,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic [BUF_AW-1:0]      rd_addr
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] rdata_q;

    tx_state_e         state_q;
    logic [5:0]        count_q;
    logic [BUF_AW-1:0] rd_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              tx_start_q;
    logic              frame_done;

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_addr = rd_addr_q;

    // Buffer: never reset. The read is registered and only performed in
    // FETCH, so a same-cycle write to that address yields the old byte and
    // later rewrites cannot disturb the byte already handed to the serializer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (state_q == FETCH) begin
            rdata_q <= mem_q[rd_addr_q];
        end
    end

    // Controller: tx_start_q is raised on leaving FETCH so that it is high
    // during LOAD, exactly when rdata_q holds the fetched byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 6'd0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (len != 6'd0)) begin
                        count_q   <= clamp_len(len);
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    tx_start_q <= 1'b1;
                    state_q    <= LOAD;
                end
                LOAD: begin
                    state_q <= SEND;
                end
                SEND: begin
                    if (frame_done) begin
                        count_q   <= count_q - 6'd1;
                        rd_addr_q <= rd_addr_q + 5'd1;
                        if (count_q == 6'd1) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start_q),
        .tx_data   (rdata_q),
        .tx        (tx),
        .frame_done(frame_done)
    );

endmodule

// File: doc/uart_tx_streamer.md
# uart_tx_streamer

Transmit-side counterpart of the receive-side byte buffer. Holds a 32-entry × 8-bit buffer that a host writes by address. On a `start` command it reads `len` bytes sequentially from address 0 and serializes each one onto `tx` as an 8N1 UART frame. Sits between the host and the UART pin; `busy` and `done` report stream status to the host.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal values are ≥ 2.
- `DEPTH`, default 32: buffer entries. Fixed at 32; the address width is 5.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high, on clock `clk`.
- `wr_en`  in  1  buffer write strobe; one byte is written per cycle while high.
- `wr_addr`  in  5  buffer write address.
- `wr_data`  in  8  buffer write data.
- `start`  in  1  stream request; sampled only in IDLE.
- `len`  in  6  number of bytes to send; sampled with `start`.
- `tx`  out  1  UART serial line; idles high.
- `busy`  out  1  high from start acceptance until the stream completes.
- `done`  out  1  single-cycle pulse when the last stop bit completes.
- `rd_addr`  out  5  address of the byte currently being fetched or sent.

## Operation
- Buffer:
  - Writes are accepted in every state, including mid-stream.
  - The buffer is not cleared by reset.
  - Reads are synchronous with 1-cycle latency.
  - A read and a write to the same address in the same cycle returns the old data.
- Start acceptance, in IDLE only:
  - `start=1` with `len=0`: ignored, no `done`.
  - `len` 33–63: clamped to 32.
  - `start` while `busy=1`: ignored.
- On acceptance:
  - The remaining count is loaded with the clamped `len`, and `rd_addr` is set to 0.
  - `busy` goes high the next cycle.
- Controller FSM states: IDLE, FETCH, LOAD, SEND, DONE.
  - IDLE → FETCH on accepted start.
  - FETCH: `rd_addr` is presented to the buffer → LOAD.
  - LOAD: read data is latched into the serializer and a 1-cycle `tx_start` is pulsed → SEND.
  - SEND: waits for the serializer `frame_done`. On it, the remaining count is decremented and `rd_addr` is incremented. Go to FETCH if the count is nonzero, otherwise DONE.
  - DONE: `done=1` for one cycle, `busy=0` in the same cycle → IDLE.
- Serializer frame:
  - Start bit 0, then data bits 0..7 (LSB first), then stop bit 1.
  - Each bit is held exactly `CLKS_PER_BIT` cycles, so a frame is 10·`CLKS_PER_BIT` cycles.
  - `frame_done` pulses on the last cycle of the stop bit.
- Data is read at FETCH time. A byte rewritten before its FETCH is sent with the new value; a rewrite after FETCH does not affect the frame in flight.
- `rd_addr` wraps 31→0 arithmetically but never advances past 31 in practice, because the count is ≤ 32.
- `rst` in any state:
  - Next cycle: `tx=1`, `busy=0`, `done=0`, `rd_addr=0`, FSM in IDLE, serializer idle.
  - The frame in flight is truncated and no `done` is issued.

## Timing
- Reset values: `tx=1`, `busy=0`, `done=0`, `rd_addr=0`.
- `start` is sampled at edge 0:
  - `busy` is high from cycle 1.
  - FETCH is cycle 1 and LOAD is cycle 2.
  - The `tx` start bit begins at cycle 3.
- Inter-frame gap: exactly 2 cycles of `tx=1` (FETCH, LOAD) between a stop bit's end and the next start bit.
- `done` is asserted in the cycle immediately after the last stop bit's final cycle.
- Total stream from the `start` edge to `done`: L·(10·`CLKS_PER_BIT` + 2) + 1 cycles.
- `start` may be re-asserted in the cycle after `done`. It is accepted, because the FSM is in IDLE.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, FETCH, LOAD, SEND, DONE).
  - `UART_DATA_W=8`, `BUF_DEPTH=32`, `BUF_AW=5`, default `CLKS_PER_BIT`.
- Sub-module `uart_tx_serializer`:
  - Inputs: `clk`, `rst`, `tx_start`, `tx_data[7:0]`.
  - Outputs: `tx`, `frame_done`.
  - Internals: bit counter 0–9 and baud counter.
- The buffer array and controller FSM live in the top level.

## Test plan
- **Single byte.** `CLKS_PER_BIT=4`. Write 0x41 to address 0, then `start`, `len=1`.
  - `tx` from cycle 3 is, per 4-cycle bit: 0,1,0,0,0,0,0,1,0,1.
  - `done` pulses at cycle 43 and `busy` falls with it.
- **Full buffer.** Write address i = i for all 32 entries, then `len=32`.
  - 32 frames carry 0x00..0x1F in order, with 2-cycle gaps between them.
  - `done` pulses at cycle 32·42+1 = 1345.
- **Length boundaries.**
  - `len=0` → no `busy`, no `done`, `tx` stays 1.
  - `len=40` → exactly 32 frames are sent.
- **Ignored start.** Assert `start` during frame 2 of a `len=3` stream.
  - Exactly 3 frames are sent and one `done`.
  - A `start` in the cycle after `done` begins a new stream.
- **Live rewrite.** During a `len=2` stream of 0x11,0x22, write 0x99 to address 1 while frame 0 is in SEND → the second frame carries 0x99.
- **Reset mid-frame.** Assert `rst` at bit 4 of frame 0.
  - Next cycle: `tx=1`, `busy=0`, `rd_addr=0`, and no `done`.
  - A new `start` afterwards replays from address 0 with the buffer contents intact.
